logic_shift_unit: RTL and testbench

//  Parametrised successor to the 24-bit combinational logic unit in the ALU datapath.

---
 rtl/logic_shift_unit_pkg.sv | 13 +
 rtl/logic_shift_unit_shift_step.sv | 15 +
 rtl/logic_shift_unit.sv | 97 +++++++++
 tb/tb_logic_shift_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/logic_shift_unit_pkg.sv
// logic_shift_unit_pkg: shared ALU op encodings, default width and FSM state type
package logic_shift_unit_pkg;
  localparam int DEF_WIDTH = 24;
  localparam logic [2:0] OP_OR  = 3'b000;
  localparam logic [2:0] OP_EOR = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_LSR = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_LSL = 3'b110;
  localparam logic [2:0] OP_ROL = 3'b111;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/logic_shift_unit_shift_step.sv
// shift_step: combinational single-bit shift/rotate; left selects LSL/ROL, rot selects rotate
module shift_step #(
  parameter int WIDTH = 24
) (
  input  logic             left,
  input  logic             rot,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] y,
  output logic             c
);
  always_comb begin
    y = left ? {w[WIDTH-2:0], rot & w[WIDTH-1]} : {rot & w[0], w[WIDTH-1:1]};
    c = left ? w[WIDTH-1] : w[0];
  end
endmodule

// File: rtl/logic_shift_unit.sv
// logic_shift_unit: one-cycle logic ops and iterative 1-bit/cycle shifts with registered result and flags
module logic_shift_unit
  import logic_shift_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);
  state_t state, state_nx;
  logic [WIDTH-1:0] work, step_y, logic_res, res;
  logic [CNT_W-1:0] rem;
  logic [1:0] op_r;
  logic step_c, fin, res_c, load;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .left(op_r[1]),
    .rot (op_r[0]),
    .w   (work),
    .y   (step_y),
    .c   (step_c)
  );
  always_comb begin
    logic_res = op == OP_OR  ? in1 | in2 :
                op == OP_EOR ? in1 ^ in2 :
                op == OP_AND ? in1 & in2 : ~in1;
    state_nx = state;
    fin = 1'b0;
    load = 1'b0;
    res = out;
    res_c = 1'b0;
    if (state == IDLE) begin
      if (start && !op[2]) begin
        fin = 1'b1;
        res = logic_res;
      end else if (start && cnt == '0) begin
        fin = 1'b1;
        res = in1;
      end else if (start) begin
        load = 1'b1;
        state_nx = SHIFT;
      end
    end else if (rem == CNT_W'(1)) begin
      fin = 1'b1;
      res = step_y;
      res_c = step_c;
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // work/rem only advance while iterating; out and flags move on completion edges alone
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      out <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      work <= '0;
      rem <= '0;
      op_r <= '0;
    end else begin
      done <= fin;
      if (fin) begin
        out <= res;
        flag_n <= res[WIDTH-1];
        flag_z <= res == '0;
        flag_c <= res_c;
      end
      if (load) begin
        work <= in1;
        rem <= cnt;
        op_r <= op[1:0];
      end else if (state == SHIFT) begin
        work <= step_y;
        rem <= rem - CNT_W'(1);
      end
    end
  end
  assign busy = state == SHIFT;
  assign flag_v = 1'b0;
endmodule

// File: tb/tb_logic_shift_unit.sv
// tb_logic_shift_unit: scoreboard bench with directed spec vectors plus randomized ops vs arithmetic model
module tb_logic_shift_unit;
  logic clk = 0, reset = 1, start = 0;
  logic [2:0] op = 0;
  logic [4:0] cnt = 0;
  logic [23:0] in1 = 0, in2 = 0;
  logic busy, done, flag_n, flag_z, flag_c, flag_v;
  logic [23:0] out;
  int total = 0, bad = 0, cyc = 0, bs = -1, be = -1;
  typedef struct {logic [23:0] o; logic c; int cy;} exp_t;
  exp_t q[$];

  logic_shift_unit #(.WIDTH(24), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cnt(cnt), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  function automatic void model(input logic [2:0] o, input int n, input logic [23:0] a, input logic [23:0] b,
                                output logic [23:0] r, output logic c);
    c = 0;
    case (o)
      3'd0: r = a | b;
      3'd1: r = a ^ b;
      3'd2: r = a & b;
      3'd3: r = ~a;
      3'd4: begin r = n >= 24 ? 24'h0 : a >> n; c = (n > 0 && n <= 24) ? a[n-1] : 1'b0; end
      3'd5: begin r = (a >> (n % 24)) | (a << (24 - n % 24)); c = n > 0 ? a[(n-1) % 24] : 1'b0; end
      3'd6: begin r = n >= 24 ? 24'h0 : a << n; c = (n > 0 && n <= 24) ? a[24-n] : 1'b0; end
      default: begin r = (a << (n % 24)) | (a >> (24 - n % 24)); c = n > 0 ? a[23 - (n-1) % 24] : 1'b0; end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(cyc > bs && cyc <= be));
      if (done) begin
        if (q.size() == 0) chk("spurious_done", 32'(done), 32'(0));
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc, e.cy);
          chk("out", 32'(out), 32'(e.o));
          chk("flag_n", 32'(flag_n), 32'(e.o[23]));
          chk("flag_z", 32'(flag_z), 32'(e.o == 0));
          chk("flag_c", 32'(flag_c), 32'(e.c));
          chk("flag_v", 32'(flag_v), 32'(0));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [4:0] n, input logic [23:0] a, input logic [23:0] b,
                       input bit fixed, input logic [23:0] eo, input logic ec, input bit keep);
    int k = 0;
    exp_t e;
    while (busy && k < 200) begin @(posedge clk); #1; k++; end
    if (busy) chk("wait_idle", 32'(busy), 32'(0));
    start = 1; op = o; cnt = n; in1 = a; in2 = b;
    if (fixed) begin e.o = eo; e.c = ec; end
    else model(o, int'(n), a, b, e.o, e.c);
    e.cy = cyc + 1 + ((o[2] && n != 0) ? int'(n) : 0);
    if (keep) q.push_back(e);
    if (o[2] && n != 0) begin bs = cyc; be = cyc + int'(n); end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || busy) && k < 200) begin @(posedge clk); #1; k++; end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_out", 32'(out), 0);
    chk("rst_flags", {28'h0, flag_n, flag_z, flag_c, flag_v}, 0);
    chk("rst_busy_done", {30'h0, busy, done}, 0);
    issue(3'd0, 5'd0, 24'hF0F0F0, 24'h0F0F00, 1, 24'hFFFFF0, 0, 1);
    issue(3'd1, 5'd0, 24'hF0F0F0, 24'h0F0F00, 1, 24'hFFFFF0, 0, 1);
    issue(3'd2, 5'd0, 24'h123456, 24'h000000, 1, 24'h000000, 0, 1);
    issue(3'd3, 5'd0, 24'h000000, 24'h000000, 1, 24'hFFFFFF, 0, 1);
    issue(3'd4, 5'd4, 24'h80000F, 24'h0, 1, 24'h080000, 1, 1);
    issue(3'd7, 5'd24, 24'hA5A5A5, 24'h0, 1, 24'hA5A5A5, 1, 1);
    issue(3'd6, 5'd0, 24'h400000, 24'h0, 1, 24'h400000, 0, 1);
    issue(3'd6, 5'd31, 24'hFFFFFF, 24'h0, 1, 24'h000000, 0, 1);
    drain();
    issue(3'd4, 5'd10, 24'hABCDEF, 24'h0, 0, 0, 0, 1);
    @(posedge clk); #1;
    start = 1; op = 3'd2; in1 = 24'hFFFFFF; in2 = 24'hFFFFFF;
    @(posedge clk); #1;
    start = 0;
    drain();
    issue(3'd5, 5'd8, 24'h123456, 24'h0, 0, 0, 0, 0);
    reset = 1;
    be = cyc;
    @(posedge clk); #1;
    reset = 0;
    chk("midrst_out", 32'(out), 0);
    chk("midrst_flags", {28'h0, flag_n, flag_z, flag_c, flag_v}, 0);
    chk("midrst_busy_done", {30'h0, busy, done}, 0);
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      logic [4:0] n;
      o = 3'($urandom_range(0, 7));
      n = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(o, n, 24'($urandom), 24'($urandom), 0, 0, 0, 1);
    end
    drain();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
